// File: rtl/vslc_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// vslc_fetch_sequencer
//
// Streams VSLC program bytes out of an external SPI flash (READ 0x03, 24-bit
// address) and hands them to the executor one at a time. Each presented byte
// appears on instr and is followed by a two-cycle instr_ready strobe; the
// executor acts on the strobe's falling edge. A 0xFF byte ends the scan
// unless the previously presented byte was a sparam opcode (0xEx), in which
// case the 0xFF is operand data. A byte limit guards against a runaway
// program. The block also owns the per-scan input image and a free-running
// cycle counter.
//
// Ports:
//   clk          sole clock, rising edge
//   rst          synchronous active-high reset
//   run          enable scanning (sampled at scan start and at scan end)
//   ui_in[7:0]   raw inputs
//   spi_miso     flash data out
//   spi_cs_n     flash chip select, active low
//   spi_sclk     SPI clock, mode 0, clk/2
//   spi_mosi     command/address bit, MSB first
//   instr[7:0]   current program byte
//   instr_ready  byte-valid strobe, 2 cycles high
//   ui_scan[7:0] ui_in snapshot for the current scan
//   ui_in_prev   ui_in snapshot for the previous scan
//   counter      free-running 16-bit cycle counter
//   scan_done    one-cycle pulse in the end-of-scan cycle
// -----------------------------------------------------------------------------
module vslc_fetch_sequencer #(
    parameter logic [23:0] BASE_ADDR      = 24'h000000,
    parameter int          MAX_LEN        = 256,
    parameter int          CS_HIGH_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [7:0]  ui_in,
    input  logic        spi_miso,
    output logic        spi_cs_n,
    output logic        spi_sclk,
    output logic        spi_mosi,
    output logic [7:0]  instr,
    output logic        instr_ready,
    output logic [7:0]  ui_scan,
    output logic [7:0]  ui_in_prev,
    output logic [15:0] counter,
    output logic        scan_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GAP,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_END
    } state_t;

    localparam int                GAP_W    = (CS_HIGH_CYCLES > 1) ? $clog2(CS_HIGH_CYCLES) : 1;
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(CS_HIGH_CYCLES - 1);
    localparam logic [15:0]       LEN_LAST = 16'(MAX_LEN - 1);
    localparam logic [31:0]       CMD_WORD = {8'h03, BASE_ADDR};

    state_t             state_reg, state_next;
    logic               phase_reg, phase_next;         // 0: sclk low half, 1: sclk high half
    logic [4:0]         bit_cnt_reg, bit_cnt_next;
    logic [31:0]        cmd_shift_reg, cmd_shift_next;
    logic [6:0]         data_shift_reg, data_shift_next;
    logic               cs_n_reg, cs_n_next;
    logic               mosi_reg, mosi_next;
    logic [7:0]         instr_reg, instr_next;
    logic [1:0]         strobe_cnt_reg, strobe_cnt_next;
    logic [7:0]         ui_scan_reg, ui_scan_next;
    logic [7:0]         ui_prev_reg, ui_prev_next;
    logic [15:0]        counter_reg;
    logic               scan_done_reg, scan_done_next;
    logic [15:0]        byte_cnt_reg, byte_cnt_next;
    logic [GAP_W-1:0]   gap_cnt_reg, gap_cnt_next;

    logic               start_scan;
    logic [7:0]         assembled;
    logic               is_end_byte;

    // The 8th bit is taken straight from the pin on the edge that completes
    // the byte, so the byte is available without an extra cycle.
    assign assembled   = {data_shift_reg, spi_miso};
    // 0xFF directly after a sparam opcode (upper nibble 0xE) is an operand.
    assign is_end_byte = (assembled == 8'hFF) && (instr_reg[7:4] != 4'hE);

    always_comb begin
        state_next      = state_reg;
        phase_next      = phase_reg;
        bit_cnt_next    = bit_cnt_reg;
        cmd_shift_next  = cmd_shift_reg;
        data_shift_next = data_shift_reg;
        cs_n_next       = cs_n_reg;
        mosi_next       = mosi_reg;
        instr_next      = instr_reg;
        ui_scan_next    = ui_scan_reg;
        ui_prev_next    = ui_prev_reg;
        byte_cnt_next   = byte_cnt_reg;
        gap_cnt_next    = gap_cnt_reg;
        start_scan      = 1'b0;
        // Strobe counter: 3 = byte loaded, 2..1 = instr_ready high, 0 = idle.
        strobe_cnt_next = (strobe_cnt_reg != 2'd0) ? strobe_cnt_reg - 2'd1 : 2'd0;

        case (state_reg)
            S_IDLE: begin
                if (run) begin
                    start_scan = 1'b1;
                end
            end
            S_GAP: begin
                if (gap_cnt_reg == GAP_LAST) begin
                    gap_cnt_next = '0;
                    if (run) begin
                        start_scan = 1'b1;
                    end else begin
                        state_next = S_IDLE;
                    end
                end else begin
                    gap_cnt_next = gap_cnt_reg + GAP_W'(1);
                end
            end
            S_CMD, S_ADDR: begin
                phase_next = ~phase_reg;
                if (phase_reg) begin
                    // Bit cell ends: sclk falls and the next bit goes out.
                    mosi_next      = cmd_shift_reg[31];
                    cmd_shift_next = {cmd_shift_reg[30:0], 1'b0};
                    bit_cnt_next   = bit_cnt_reg + 5'd1;
                    if (state_reg == S_CMD && bit_cnt_reg == 5'd7) begin
                        state_next   = S_ADDR;
                        bit_cnt_next = 5'd0;
                    end else if (state_reg == S_ADDR && bit_cnt_reg == 5'd23) begin
                        state_next   = S_DATA;
                        bit_cnt_next = 5'd0;
                        mosi_next    = 1'b0;
                    end
                end
            end
            S_DATA: begin
                phase_next = ~phase_reg;
                if (phase_reg) begin
                    data_shift_next = assembled[6:0];
                    bit_cnt_next    = bit_cnt_reg + 5'd1;
                    if (bit_cnt_reg == 5'd7) begin
                        bit_cnt_next = 5'd0;
                        if (is_end_byte) begin
                            state_next = S_END;
                        end else begin
                            instr_next      = assembled;
                            strobe_cnt_next = 2'd3;
                            byte_cnt_next   = byte_cnt_reg + 16'd1;
                            if (byte_cnt_reg == LEN_LAST) begin
                                state_next = S_END;
                            end
                        end
                    end
                end
            end
            S_END: begin
                cs_n_next     = 1'b1;
                ui_prev_next  = ui_scan_reg;
                ui_scan_next  = ui_in;
                byte_cnt_next = 16'd0;
                gap_cnt_next  = '0;
                state_next    = S_GAP;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        if (start_scan) begin
            state_next     = S_CMD;
            cs_n_next      = 1'b0;
            phase_next     = 1'b0;
            bit_cnt_next   = 5'd0;
            mosi_next      = CMD_WORD[31];
            cmd_shift_next = {CMD_WORD[30:0], 1'b0};
        end

        scan_done_next = (state_next == S_END);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            phase_reg      <= 1'b0;
            bit_cnt_reg    <= 5'd0;
            cmd_shift_reg  <= 32'd0;
            data_shift_reg <= 7'd0;
            cs_n_reg       <= 1'b1;
            mosi_reg       <= 1'b0;
            instr_reg      <= 8'd0;
            strobe_cnt_reg <= 2'd0;
            ui_scan_reg    <= 8'd0;
            ui_prev_reg    <= 8'd0;
            scan_done_reg  <= 1'b0;
            byte_cnt_reg   <= 16'd0;
            gap_cnt_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            phase_reg      <= phase_next;
            bit_cnt_reg    <= bit_cnt_next;
            cmd_shift_reg  <= cmd_shift_next;
            data_shift_reg <= data_shift_next;
            cs_n_reg       <= cs_n_next;
            mosi_reg       <= mosi_next;
            instr_reg      <= instr_next;
            strobe_cnt_reg <= strobe_cnt_next;
            ui_scan_reg    <= ui_scan_next;
            ui_prev_reg    <= ui_prev_next;
            scan_done_reg  <= scan_done_next;
            byte_cnt_reg   <= byte_cnt_next;
            gap_cnt_reg    <= gap_cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            counter_reg <= 16'd0;
        end else begin
            counter_reg <= counter_reg + 16'd1;
        end
    end

    assign spi_cs_n    = cs_n_reg;
    assign spi_sclk    = phase_reg;     // high half of every bit cell
    assign spi_mosi    = mosi_reg;
    assign instr       = instr_reg;
    assign instr_ready = (strobe_cnt_reg == 2'd2) || (strobe_cnt_reg == 2'd1);
    assign ui_scan     = ui_scan_reg;
    assign ui_in_prev  = ui_prev_reg;
    assign counter     = counter_reg;
    assign scan_done   = scan_done_reg;

endmodule

// File: tb/tb_vslc_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_vslc_fetch_sequencer
//
// Directed bench: a negedge flash model serves bytes from a small array and
// records the command/address word; a monitor logs every instr_ready rising
// edge, strobe width, cs_n low/high run lengths and scan_done pulses. The
// initial block walks through reset, a basic scan, a sparam operand scan, a
// runaway scan with run dropped mid-scan, and a reset in the middle of DATA.
// -----------------------------------------------------------------------------
module tb_vslc_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic [7:0]  ui_in = 8'h00;
    logic        spi_miso = 1'b0;
    logic        spi_cs_n;
    logic        spi_sclk;
    logic        spi_mosi;
    logic [7:0]  instr;
    logic        instr_ready;
    logic [7:0]  ui_scan;
    logic [7:0]  ui_in_prev;
    logic [15:0] counter;
    logic        scan_done;

    always #5 clk = ~clk;

    vslc_fetch_sequencer #(
        .BASE_ADDR      (24'h000000),
        .MAX_LEN        (4),
        .CS_HIGH_CYCLES (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .ui_in       (ui_in),
        .spi_miso    (spi_miso),
        .spi_cs_n    (spi_cs_n),
        .spi_sclk    (spi_sclk),
        .spi_mosi    (spi_mosi),
        .instr       (instr),
        .instr_ready (instr_ready),
        .ui_scan     (ui_scan),
        .ui_in_prev  (ui_in_prev),
        .counter     (counter),
        .scan_done   (scan_done)
    );

    int          checks = 0;
    int          errors = 0;

    logic [7:0]  flash_mem [0:15];
    int          rise_cnt  = 0;
    logic [31:0] cmd_rx    = 32'd0;
    int          lowcnt    = 0;
    int          highcnt   = 0;
    int          last_high = 0;
    logic        prev_cs   = 1'b1;
    logic        prev_rdy  = 1'b0;
    int          rdy_len   = 0;
    int          last_len  = 0;
    int          done_cnt  = 0;
    logic [7:0]  strb_q [$];
    int          mon_idx;
    int          mon_bit;

    // Flash model and monitor, both evaluated on the falling clock edge.
    always @(negedge clk) begin
        if (!spi_cs_n) begin
            if (prev_cs) begin
                last_high = highcnt;
                lowcnt    = 1;
            end else begin
                lowcnt = lowcnt + 1;
            end
        end else begin
            highcnt = prev_cs ? highcnt + 1 : 1;
        end
        prev_cs = spi_cs_n;

        if (spi_cs_n) begin
            rise_cnt = 0;
        end else if (spi_sclk) begin
            if (rise_cnt < 32) begin
                cmd_rx = {cmd_rx[30:0], spi_mosi};
            end else begin
                mon_idx = (rise_cnt - 32) / 8;
                if (mon_idx > 15) mon_idx = 15;
                mon_bit  = 7 - ((rise_cnt - 32) % 8);
                spi_miso = flash_mem[mon_idx][mon_bit];
            end
            rise_cnt = rise_cnt + 1;
        end

        if (instr_ready && !prev_rdy) strb_q.push_back(instr);
        if (instr_ready) begin
            rdy_len = rdy_len + 1;
        end else if (prev_rdy) begin
            last_len = rdy_len;
            rdy_len  = 0;
        end
        prev_rdy = instr_ready;

        if (scan_done) done_cnt = done_cnt + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input int bound, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (scan_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_strobe(input int base, input int bound, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (strb_q.size() > base) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    function automatic logic [31:0] strb_at(input int i);
        if (i < strb_q.size()) return {24'h0, strb_q[i]};
        return 32'hFFFF_FFFF;
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_cs_n"},   {31'd0, spi_cs_n},    32'd1);
        check({tag, "_sclk"},   {31'd0, spi_sclk},    32'd0);
        check({tag, "_mosi"},   {31'd0, spi_mosi},    32'd0);
        check({tag, "_instr"},  {24'd0, instr},       32'd0);
        check({tag, "_ready"},  {31'd0, instr_ready}, 32'd0);
        check({tag, "_uiscan"}, {24'd0, ui_scan},     32'd0);
        check({tag, "_uiprev"}, {24'd0, ui_in_prev},  32'd0);
        check({tag, "_cnt"},    {16'd0, counter},     32'd0);
        check({tag, "_done"},   {31'd0, scan_done},   32'd0);
    endtask

    initial begin
        int   base;
        int   done0;
        logic ok;

        for (int i = 0; i < 16; i++) flash_mem[i] = 8'h00;

        // ---------------- reset ----------------
        rst = 1'b1;
        repeat (3) @(posedge clk);
        tick();
        check_reset_values("reset");
        rst = 1'b0;
        tick();
        check("counter_after_release", {16'd0, counter}, 32'd1);
        $display("step reset: done");

        // ---------------- scan 1: 01 90 FF ----------------
        flash_mem[0] = 8'h01; flash_mem[1] = 8'h90; flash_mem[2] = 8'hFF;
        ui_in = 8'hA5;
        base  = strb_q.size();
        done0 = done_cnt;
        run   = 1'b1;
        wait_done(300, ok);
        check("scan1_done_seen", {31'd0, ok}, 32'd1);
        check("scan1_length", lowcnt, 32'd113);
        check("scan1_cmd_addr", cmd_rx, 32'h0300_0000);
        flash_mem[0] = 8'hE8; flash_mem[1] = 8'hFF; flash_mem[2] = 8'h01; flash_mem[3] = 8'hFF;
        tick();
        check("scan1_ui_scan", {24'd0, ui_scan}, 32'hA5);
        check("scan1_ui_prev", {24'd0, ui_in_prev}, 32'h00);
        ui_in = 8'h3C;
        repeat (3) tick();
        check("scan1_strobes", strb_q.size() - base, 32'd2);
        check("scan1_byte0", strb_at(base), 32'h01);
        check("scan1_byte1", strb_at(base + 1), 32'h90);
        check("scan1_done_pulses", done_cnt - done0, 32'd1);
        check("strobe_width", last_len, 32'd2);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (!spi_cs_n) begin
                ok = 1'b1;
                break;
            end
        end
        check("scan_restart", {31'd0, ok}, 32'd1);
        check("gap_ge_4", {31'd0, (last_high >= 4)}, 32'd1);
        $display("step scan1: strobes=%0d gap=%0d", strb_q.size() - base, last_high);

        // ---------------- scan 2: sparam operand E8 FF 01 FF ----------------
        base = strb_q.size();
        wait_strobe(base, 150, ok);
        check("scan2_first_strobe", {31'd0, ok}, 32'd1);
        check("scan2_mid_ui_scan", {24'd0, ui_scan}, 32'hA5);
        check("scan2_mid_ui_prev", {24'd0, ui_in_prev}, 32'h00);
        wait_done(300, ok);
        check("scan2_done_seen", {31'd0, ok}, 32'd1);
        check("scan2_length", lowcnt, 32'd129);
        for (int i = 0; i < 16; i++) flash_mem[i] = 8'h00;
        tick();
        check("scan2_ui_scan", {24'd0, ui_scan}, 32'h3C);
        check("scan2_ui_prev", {24'd0, ui_in_prev}, 32'hA5);
        repeat (3) tick();
        check("scan2_strobes", strb_q.size() - base, 32'd3);
        check("scan2_byte0", strb_at(base), 32'hE8);
        check("scan2_byte1", strb_at(base + 1), 32'hFF);
        check("scan2_byte2", strb_at(base + 2), 32'h01);
        $display("step scan2: strobes=%0d", strb_q.size() - base);

        // ---------------- scan 3: runaway, run dropped in byte 2 ----------------
        base  = strb_q.size();
        done0 = done_cnt;
        wait_strobe(base, 200, ok);
        check("scan3_first_strobe", {31'd0, ok}, 32'd1);
        run = 1'b0;
        wait_done(300, ok);
        check("scan3_done_seen", {31'd0, ok}, 32'd1);
        check("scan3_length", lowcnt, 32'd129);
        repeat (4) tick();
        check("scan3_strobes", strb_q.size() - base, 32'd4);
        check("scan3_byte0", strb_at(base), 32'h00);
        check("scan3_byte3", strb_at(base + 3), 32'h00);
        check("scan3_last_width", last_len, 32'd2);
        repeat (30) tick();
        check("idle_cs_n_high", {31'd0, spi_cs_n}, 32'd1);
        check("idle_no_restart", {31'd0, (highcnt >= 30)}, 32'd1);
        check("idle_done_pulses", done_cnt - done0, 32'd1);
        $display("step scan3: strobes=%0d", strb_q.size() - base);

        // ---------------- scan 4: reset in the middle of DATA ----------------
        flash_mem[0] = 8'h55; flash_mem[1] = 8'hAA;
        base = strb_q.size();
        run  = 1'b1;
        ok   = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (!spi_cs_n && lowcnt == 96) begin
                ok = 1'b1;
                break;
            end
        end
        check("scan4_reached_byte2_end", {31'd0, ok}, 32'd1);
        check("scan4_instr_before_rst", {24'd0, instr}, 32'h55);
        rst = 1'b1;
        tick();
        check_reset_values("midrst");
        rst = 1'b0;
        run = 1'b0;
        repeat (8) tick();
        check("midrst_strobes", strb_q.size() - base, 32'd1);
        check("midrst_byte0", strb_at(base), 32'h55);
        check("midrst_cs_n", {31'd0, spi_cs_n}, 32'd1);
        $display("step midrst: strobes=%0d", strb_q.size() - base);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vslc_fetch_sequencer.md
# vslc_fetch_sequencer

Instruction fetch and scan sequencer for the VSLC controller, directly upstream of the executor. It streams program bytes from an external SPI flash (READ 0x03), presents each byte on `instr` with an `instr_ready` strobe whose falling edge the executor consumes, and detects end-of-scan. It also owns the scan-stable input image (`ui_scan`, `ui_in_prev`) and the free-running `counter` that the executor uses for its timer and servo clock strobes.

## Interface
- `BASE_ADDR`, 24'h000000: flash address of the first program byte.
- `MAX_LEN`, 256: byte limit per scan, 1..65535; forces end-of-scan if no END byte arrives.
- `CS_HIGH_CYCLES`, 4: minimum `spi_cs_n`-high cycles between scans, ≥1.
- `clk`  in  1  sole clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `run`  in  1  enable scanning; sampled at scan start and scan end.
- `ui_in`  in  8  raw inputs.
- `spi_miso`  in  1  flash data out.
- `spi_cs_n`  out  1  flash chip select, active low.
- `spi_sclk`  out  1  SPI clock, mode 0, clk/2.
- `spi_mosi`  out  1  command/address bit, MSB first.
- `instr`  out  8  current program byte.
- `instr_ready`  out  1  byte-valid strobe; the executor acts on its falling edge.
- `ui_scan`  out  8  `ui_in` snapshot for the current scan.
- `ui_in_prev`  out  8  snapshot for the previous scan.
- `counter`  out  16  free-running cycle counter.
- `scan_done`  out  1  one-cycle pulse at end of scan.

## Operation
- Reset values: `spi_cs_n`=1, `spi_sclk`=0, `spi_mosi`=0, `instr`=0, `instr_ready`=0, `ui_scan`=0, `ui_in_prev`=0, `counter`=0, `scan_done`=0, state IDLE, byte count 0.
- `counter` increments every cycle regardless of `run` or state; it wraps 16'hFFFF→0.
- States:
  - IDLE: cs_n high, sclk low.
  - GAP: cs_n high, counts `CS_HIGH_CYCLES`.
  - CMD: 8 bits of 0x03.
  - ADDR: 24 bits of `BASE_ADDR`.
  - DATA: 8 bits in, per byte.
  - END: one cycle.
- Transitions:
  - IDLE→CMD when `run`=1.
  - CMD→ADDR→DATA after 8 and 24 bits.
  - DATA loops per byte until an END condition, then →END.
  - END→GAP.
  - GAP→CMD if `run`=1 after the count, else →IDLE.
- SPI bit cell is 2 clk cycles:
  - Low phase: `spi_mosi` updated.
  - High phase: `spi_sclk`=1.
  - `spi_miso` is sampled on the clk edge that returns sclk to 0.
  - In DATA, `spi_mosi` is held 0.
- Byte complete: `instr` loads the assembled byte, then `instr_ready`=1 for exactly 2 cycles, then 0. `instr` holds until the next byte completes.
- END conditions:
  - The byte is 0xFF and the previously presented byte's `[7:4]` ≠ 4'b1110 (0xFF as a sparam operand is data). An END byte is never presented: no `instr_ready`, `instr` unchanged.
  - The byte count reaches `MAX_LEN` after presenting that byte.
- In END:
  - `spi_cs_n`←1.
  - `scan_done`=1.
  - `ui_in_prev`←`ui_scan`, and `ui_scan`←`ui_in` in the same cycle.
  - The byte count clears.
- `run` dropped mid-scan: the scan completes normally, then the block parks in IDLE.
- `rst` mid-operation: all state returns to reset values on the next edge. Any partially assembled byte is discarded and no strobe is issued.

## Timing
- First `spi_sclk` rise: the 2nd cycle after leaving IDLE (cs_n falls on the IDLE→CMD edge).
- CMD+ADDR: 64 cycles.
- Byte period: 16 cycles. `instr_ready` rises 1 cycle after the 8th sample and is high for cycles 1–2 of the following byte.
- `instr` is stable ≥13 cycles after `instr_ready` falls.
- Scan of N presented bytes plus END: 64 + 16·(N+1) + 1 cycles from cs_n fall to `scan_done`, then a gap of ≥`CS_HIGH_CYCLES`.
- `ui_scan` and `ui_in_prev` change only in the END cycle.

## Test plan
- Reset: assert `rst` for 3 cycles → all outputs at reset values; `counter` reads 0, then 1 on the cycle after release.
- Basic scan: flash at `BASE_ADDR` = 0x01, 0x90, 0xFF; `run`=1.
  - MOSI carries 0x03 then 24'h000000.
  - Two strobes with `instr`=0x01 then 0x90.
  - No third strobe.
  - `scan_done` pulses once.
  - cs_n stays high ≥4 cycles, then the scan restarts.
- Sparam operand: bytes 0xE8, 0xFF, 0x01, 0xFF → three strobes (0xE8, 0xFF, 0x01); the scan ends on the final 0xFF.
- Runaway: `MAX_LEN`=4, flash all 0x00 → exactly 4 strobes, then `scan_done`; cs_n rises.
- Input image: `ui_in`=0xA5 during scan 1, 0x3C during scan 2.
  - After scan-2 END: `ui_scan`=0x3C, `ui_in_prev`=0xA5.
  - Neither changes mid-scan.
- `run` low mid-byte-2: the scan completes through END, then IDLE with cs_n high.
- `rst` mid-DATA: the next cycle shows reset values, with no `instr_ready` pulse.
